// File: rtl/my_pkg.sv
// Shared types and register offsets for the memory-mapped UART transmitter.
package my_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO feeding the UART serializer; head is visible on dout
// without a read cycle.
module uart_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged on the pre-edge count, so a push into a full FIFO is
  // dropped even when a pop frees a slot on the same edge.
  assign full    = (int'(count) == FIFO_DEPTH);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO and a
// serializer FSM driving tx_o at a programmable bit time of DIVISOR+1 clocks.
module uart_tx_periph
  import my_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en, rd_en, push, pop, full, empty, busy;
  logic [1:0]    sel;
  logic [CW-1:0] count;
  logic [7:0]    count8, head;
  logic [15:0]   divisor;
  logic          tx_en, irq_en, overflow;
  logic [31:0]   status_word;
  logic          unused_bits;

  uart_state_t   state, state_n;
  logic [15:0]   timer, timer_n, reload, reload_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          tx_n;

  assign sel         = addr_i[3:2];
  assign wr_en       = en_i & (|we_i);
  assign rd_en       = en_i & ~(|we_i);
  assign push        = wr_en & (sel == UART_TXDATA) & we_i[0];
  assign busy        = (state != IDLE);
  assign count8      = 8'(count);
  assign status_word = {16'h0, count8, 4'h0, overflow, busy, empty, full};
  assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data_i[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Bus side: registered read mux (zero when not reading), config registers,
  // sticky overflow and the registered interrupt level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o   <= '0;
      irq_o    <= 1'b0;
      divisor  <= DIV_RESET;
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      irq_o  <= irq_en & empty & ~busy;
      data_o <= '0;
      if (rd_en) begin
        case (sel)
          UART_STATUS: data_o <= status_word;
          UART_DIV:    data_o <= {16'h0, divisor};
          UART_CTRL:   data_o <= {30'h0, irq_en, tx_en};
          default:     data_o <= '0;
        endcase
      end
      if (push && full) overflow <= 1'b1;
      if (wr_en) begin
        case (sel)
          UART_STATUS: overflow <= 1'b0;
          UART_DIV: begin
            if (we_i[0]) divisor[7:0]  <= data_i[7:0];
            if (we_i[1]) divisor[15:8] <= data_i[15:8];
          end
          UART_CTRL: begin
            if (we_i[0]) begin
              tx_en  <= data_i[0];
              irq_en <= data_i[1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      reload  <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      reload  <= reload_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      tx_o    <= tx_n;
    end
  end

  // Divisor is captured into reload at frame start so mid-frame writes only
  // take effect on the following frame.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    reload_n  = reload;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tx_n      = tx_o;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && !empty) begin
          pop       = 1'b1;
          shift_n   = head;
          reload_n  = divisor;
          timer_n   = divisor;
          bit_cnt_n = 3'd0;
          tx_n      = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (timer == 16'd0) begin
          timer_n = reload;
          tx_n    = shift[0];
          state_n = DATA;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      DATA: begin
        if (timer == 16'd0) begin
          timer_n = reload;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      STOP: begin
        if (timer == 16'd0) begin
          if (tx_en && !empty) begin
            pop       = 1'b1;
            shift_n   = head;
            reload_n  = divisor;
            timer_n   = divisor;
            bit_cnt_n = 3'd0;
            tx_n      = 1'b0;
            state_n   = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: bus register behaviour plus serial
// waveforms compared against a frame-level reference model.
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [3:0]  we_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        tx_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_periph #(.FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en_i),
    .addr_i (addr_i),
    .we_i   (we_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    en_i = 1'b1; addr_i = a; we_i = w; data_i = d;
    @(negedge clk);
    en_i = 1'b0; addr_i = '0; we_i = '0; data_i = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    en_i = 1'b1; addr_i = a; we_i = '0;
    @(negedge clk);
    en_i = 1'b0; addr_i = '0;
    d = data_o;
  endtask

  // Reference model: an 8N1 frame is start(0), data LSB first, stop(1), each
  // level held for d+1 clocks.
  function automatic void add_frame(input logic [7:0] b, input int d);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int s = 0; s < 10; s++)
      for (int c = 0; c <= d; c++) exp_q.push_back(f[s]);
  endfunction

  task automatic check_stream(input string name);
    int wait_cycles = 0;
    int errs = 0;
    int first = -1;
    logic act_first = 1'b0;
    logic exp_first = 1'b0;
    while (tx_o !== 1'b0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (wait_cycles != 1) begin
      failures++;
      $display("[TB] FAIL %s_start: start latency=%0d cycles, expected 1", name, wait_cycles);
    end
    if (tx_o === 1'b0) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k > 0) @(negedge clk);
        if (tx_o !== exp_q[k]) begin
          errs++;
          if (first < 0) begin
            first = k; act_first = tx_o; exp_first = exp_q[k];
          end
        end
      end
    end else begin
      errs = exp_q.size();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL %s_wave: %0d bad cycles, first at %0d got %b expected %b",
               name, errs, first, act_first, exp_first);
    end
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_idle: tx_o=%b expected 1 after frame", name, tx_o);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || irq_o !== 1'b0 || data_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: tx=%b irq=%b data=%h expected 1 0 00000000", tx_o, irq_o, data_o);
    end
    reset = 1'b0;
    bus_read(4'h4, r);
    checks++;
    if (r !== 32'h2) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h expected 00000002", r);
    end
    bus_read(4'h8, r);
    checks++;
    if (r !== 32'h1B1) begin
      failures++;
      $display("[TB] FAIL reset_div: got %h expected 000001b1", r);
    end
    bus_read(4'hC, r);
    checks++;
    if (r !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %h expected 00000000", r);
    end
  endtask

  task automatic test_registers();
    logic [31:0] r, d;
    logic [3:0]  w;
    logic [15:0] div_m = 16'h01B1;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      w = 4'($urandom_range(1, 15));
      bus_write(4'h8, w, d);
      if (w[0]) div_m[7:0]  = d[7:0];
      if (w[1]) div_m[15:8] = d[15:8];
      bus_read(4'h8, r);
      checks++;
      if (r !== {16'h0, div_m}) begin
        failures++;
        $display("[TB] FAIL div_rw: we=%b got %h expected %h", w, r, {16'h0, div_m});
      end
    end
    bus_write(4'h8, 4'h3, 32'h0000_9A5C);
    bus_read(4'h8, r);
    @(negedge clk);
    checks++;
    if (data_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL data_idle: got %h expected 00000000 when not reading", data_o);
    end
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      bus_write(4'hC, 4'h1, d);
      bus_read(4'hC, r);
      checks++;
      if (r !== {30'h0, d[1:0]}) begin
        failures++;
        $display("[TB] FAIL ctrl_rw: got %h expected %h", r, {30'h0, d[1:0]});
      end
    end
    bus_write(4'hC, 4'h1, 32'h0);
    bus_read(4'h0, r);
    checks++;
    if (r !== 32'h0) begin
      failures++;
      $display("[TB] FAIL txdata_read: got %h expected 00000000", r);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] r;
    logic [7:0]  b;
    int          d;
    bus_write(4'hC, 4'h1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 3 : int'($urandom_range(0, 5));
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      bus_write(4'h8, 4'h3, d);
      bus_write(4'h0, 4'h1, {24'h0, b});
      add_frame(b, d);
      check_stream("single");
      bus_read(4'h4, r);
      checks++;
      if (r !== 32'h2) begin
        failures++;
        $display("[TB] FAIL single_status: got %h expected 00000002", r);
      end
    end
    bus_write(4'hC, 4'h1, 32'h0);
  endtask

  task automatic test_back_to_back();
    bus_write(4'h8, 4'h3, 32'h0);
    bus_write(4'h0, 4'h1, 32'h55);
    bus_write(4'h0, 4'h1, 32'h0F);
    add_frame(8'h55, 0);
    add_frame(8'h0F, 0);
    bus_write(4'hC, 4'h1, 32'h1);
    check_stream("b2b");
    bus_write(4'hC, 4'h1, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [7:0]  q[$];
    logic [7:0]  b;
    bus_write(4'h8, 4'h3, 32'h0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) q.push_back(b);
      bus_write(4'h0, 4'h1, {24'h0, b});
    end
    bus_read(4'h4, r);
    checks++;
    if (r !== 32'h809) begin
      failures++;
      $display("[TB] FAIL ovf_status: got %h expected 00000809", r);
    end
    bus_write(4'h4, 4'hF, $urandom);
    bus_read(4'h4, r);
    checks++;
    if (r !== 32'h801) begin
      failures++;
      $display("[TB] FAIL ovf_clear: got %h expected 00000801", r);
    end
    foreach (q[i]) add_frame(q[i], 0);
    bus_write(4'hC, 4'h1, 32'h1);
    check_stream("drain");
    bus_read(4'h4, r);
    checks++;
    if (r !== 32'h2) begin
      failures++;
      $display("[TB] FAIL drain_status: got %h expected 00000002", r);
    end
    bus_write(4'hC, 4'h1, 32'h0);
  endtask

  task automatic test_irq_tx_en();
    logic [31:0] r;
    logic [7:0]  b;
    b = 8'($urandom);
    bus_write(4'h8, 4'h3, 32'h1);
    bus_write(4'hC, 4'h1, 32'h3);
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_idle: irq_o=%b expected 1", irq_o);
    end
    bus_write(4'h0, 4'h1, {24'h0, b});
    add_frame(b, 1);
    fork
      check_stream("irq");
      begin
        repeat (6) @(negedge clk);
        bus_write(4'hC, 4'h1, 32'h2);
        bus_read(4'h4, r);
        checks++;
        if (r !== 32'h6 || irq_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL irq_busy: status=%h irq=%b expected 00000006 0", r, irq_o);
        end
      end
    join
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_early: irq_o=%b expected 0 on first idle cycle", irq_o);
    end
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_rise: irq_o=%b expected 1", irq_o);
    end
    bus_write(4'hC, 4'h1, 32'h0);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    logic [7:0]  b;
    int          highs = 0;
    b = 8'($urandom) & 8'hEF;
    bus_write(4'h8, 4'h3, 32'h3);
    bus_write(4'hC, 4'h1, 32'h1);
    bus_write(4'h0, 4'h1, {24'h0, b});
    bus_write(4'h0, 4'h1, $urandom);
    repeat (20) @(negedge clk);
    checks++;
    if (tx_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_bit4: tx_o=%b expected 0 during data bit 4", tx_o);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_tx: tx_o=%b expected 1 immediately", tx_o);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(4'h4, r);
    checks++;
    if (r !== 32'h2) begin
      failures++;
      $display("[TB] FAIL mid_reset_status: got %h expected 00000002", r);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_o === 1'b1) highs++;
    end
    checks++;
    if (highs != 60) begin
      failures++;
      $display("[TB] FAIL mid_reset_quiet: tx_o high %0d of 60 cycles, expected 60", highs);
    end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_irq_tx_en();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
